// File: rtl/datapath_register_file_if.sv
// datapath_register_file_if: operand read, write-back and status-flag signals between the control sequencer, the register file and the function unit
interface datapath_register_file_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [ADDR_WIDTH-1:0] dest_addr;
    logic                  mb_select;
    logic                  md_select;
    logic                  write_enable;
    logic                  flag_load;
    logic [DATA_WIDTH-1:0] constant_in;
    logic [DATA_WIDTH-1:0] function_result;
    logic [DATA_WIDTH-1:0] data_in;
    logic                  overflow;
    logic                  carry_out;
    logic                  negative;
    logic                  zero;
    logic [DATA_WIDTH-1:0] bus_a;
    logic [DATA_WIDTH-1:0] bus_b;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  status_v;
    logic                  status_c;
    logic                  status_n;
    logic                  status_z;

    modport master (
        output addr_a, addr_b, dest_addr, mb_select, md_select, write_enable, flag_load,
        output constant_in, function_result, data_in, overflow, carry_out, negative, zero,
        input  bus_a, bus_b, data_out, status_v, status_c, status_n, status_z
    );

    modport slave (
        input  addr_a, addr_b, dest_addr, mb_select, md_select, write_enable, flag_load,
        input  constant_in, function_result, data_in, overflow, carry_out, negative, zero,
        output bus_a, bus_b, data_out, status_v, status_c, status_n, status_z
    );
endinterface

// File: rtl/datapath_register_file.sv
// datapath_register_file: 8x16 register file with two combinational read ports, B-constant mux, write-back mux and VCNZ status register; DATAPATH_ZERO_REG_EN hardwires R0 to zero
module datapath_register_file #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input logic                     clock_i,
    input logic                     reset_n_i,
    datapath_register_file_if.slave rf
);
    localparam int NUM_REGS = 2 ** ADDR_WIDTH;
`ifdef DATAPATH_ZERO_REG_EN
    localparam bit ZERO_REG = 1'b1;
`else
    localparam bit ZERO_REG = 1'b0;
`endif
    localparam int FIRST_REG = ZERO_REG ? 1 : 0;

    logic [DATA_WIDTH-1:0] regs_q [FIRST_REG:NUM_REGS-1];
    logic [3:0]            status_q;
    logic [3:0]            status_d;
    logic [DATA_WIDTH-1:0] wr_data_d;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    // Reads are bypass-free so a write lands only after the edge (BusA feeds the unit combinationally)
    always_comb begin
        rd_a      = (ZERO_REG && rf.addr_a == '0) ? '0 : regs_q[rf.addr_a];
        rd_b      = (ZERO_REG && rf.addr_b == '0) ? '0 : regs_q[rf.addr_b];
        wr_data_d = rf.md_select ? rf.data_in : rf.function_result;
        status_d  = rf.flag_load ? {rf.overflow, rf.carry_out, rf.negative, rf.zero} : status_q;
    end

    assign rf.bus_a    = rd_a;
    assign rf.bus_b    = rf.mb_select ? rf.constant_in : rd_b;
    assign rf.data_out = rd_b;
    assign {rf.status_v, rf.status_c, rf.status_n, rf.status_z} = status_q;

    // Write-back of the selected data; writes to the hardwired zero register are dropped
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else if (rf.write_enable && !(ZERO_REG && rf.dest_addr == '0)) begin
            regs_q[rf.dest_addr] <= wr_data_d;
        end
    end

    // Status flags latch independently of write-back
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) status_q <= '0;
        else status_q <= status_d;
    end
endmodule

// File: tb/tb_datapath_register_file.sv
// tb_datapath_register_file: directed vectors with literal expectations plus a per-cycle reference model check
module tb_datapath_register_file;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int checks = 0;
    int errors = 0;

    datapath_register_file_if #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) rf ();
    datapath_register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clock_i(clk),
        .reset_n_i(rst_n),
        .rf(rf.slave)
    );

    always #5 clk = ~clk;

`ifdef DATAPATH_ZERO_REG_EN
    localparam bit ZREG = 1'b1;
`else
    localparam bit ZREG = 1'b0;
`endif

    // Reference model: architectural register contents and status nibble
    logic [15:0] m_r [8] = '{default: 16'h0};
    logic [3:0]  m_s = 4'h0;

    function automatic logic [15:0] m_read(input logic [2:0] a);
        return (ZREG && a == 3'd0) ? 16'h0 : m_r[a];
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) m_r[i] <= 16'h0;
            m_s <= 4'h0;
        end else begin
            if (rf.write_enable) m_r[rf.dest_addr] <= rf.md_select ? rf.data_in : rf.function_result;
            if (rf.flag_load) m_s <= {rf.overflow, rf.carry_out, rf.negative, rf.zero};
        end
    end

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare of all outputs against the model, away from the rising edge
    always @(negedge clk) begin
        chk("model bus_a", rf.bus_a, m_read(rf.addr_a));
        chk("model bus_b", rf.bus_b, rf.mb_select ? rf.constant_in : m_read(rf.addr_b));
        chk("model data_out", rf.data_out, m_read(rf.addr_b));
        chk("model status", {12'h0, rf.status_v, rf.status_c, rf.status_n, rf.status_z}, {12'h0, m_s});
    end

    function automatic logic [15:0] st();
        return {12'h0, rf.status_v, rf.status_c, rf.status_n, rf.status_z};
    endfunction

    task automatic step();
        @(negedge clk);
        #2;
    endtask

    task automatic idle();
        rf.write_enable = 1'b0;
        rf.flag_load    = 1'b0;
    endtask

    initial begin
        rf.addr_a = '0; rf.addr_b = '0; rf.dest_addr = '0;
        rf.mb_select = 1'b0; rf.md_select = 1'b0;
        rf.write_enable = 1'b0; rf.flag_load = 1'b0;
        rf.constant_in = '0; rf.function_result = '0; rf.data_in = '0;
        rf.overflow = 1'b0; rf.carry_out = 1'b0; rf.negative = 1'b0; rf.zero = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        // Reset readback sweep over all addresses
        for (int i = 0; i < 8; i++) begin
            rf.addr_a = 3'(i); rf.addr_b = 3'(7 - i);
            #1;
            chk("reset bus_a", rf.bus_a, 16'h0000);
            chk("reset data_out", rf.data_out, 16'h0000);
        end
        chk("reset status", st(), 16'h0000);
        // Write R3, no bypass before the edge
        step();
        rf.write_enable = 1'b1; rf.dest_addr = 3'd3; rf.md_select = 1'b0;
        rf.function_result = 16'hA5C3; rf.addr_a = 3'd3; rf.addr_b = 3'd3;
        #1 chk("no bypass bus_a", rf.bus_a, 16'h0000);
        step();
        idle();
        chk("write R3 bus_a", rf.bus_a, 16'hA5C3);
        chk("same addr bus_b", rf.bus_b, 16'hA5C3);
        rf.addr_a = 3'd2; rf.addr_b = 3'd4;
        #1 chk("R2 untouched", rf.bus_a, 16'h0000);
        chk("R4 untouched", rf.data_out, 16'h0000);
        // MD select writes DataIn into R5, then B mux
        rf.write_enable = 1'b1; rf.dest_addr = 3'd5; rf.md_select = 1'b1;
        rf.data_in = 16'h1234; rf.function_result = 16'hDEAD;
        step();
        idle();
        rf.addr_b = 3'd5; rf.mb_select = 1'b0;
        #1 chk("md data_out", rf.data_out, 16'h1234);
        chk("md bus_b", rf.bus_b, 16'h1234);
        rf.mb_select = 1'b1; rf.constant_in = 16'h00FF;
        #1 chk("mb const bus_b", rf.bus_b, 16'h00FF);
        chk("mb data_out", rf.data_out, 16'h1234);
        // Flag latch and hold, no write occurring
        rf.flag_load = 1'b1;
        {rf.overflow, rf.carry_out, rf.negative, rf.zero} = 4'b1010;
        step();
        chk("flag latch", st(), 16'h000A);
        rf.flag_load = 1'b0;
        {rf.overflow, rf.carry_out, rf.negative, rf.zero} = 4'b0101;
        step();
        chk("flag hold", st(), 16'h000A);
        // Flags latch alongside an MD=1 write
        rf.flag_load = 1'b1; rf.write_enable = 1'b1; rf.md_select = 1'b1;
        rf.dest_addr = 3'd7; rf.data_in = 16'h8001;
        step();
        idle();
        rf.addr_a = 3'd7;
        #1 chk("flag with md write", st(), 16'h0005);
        chk("R7 data_in", rf.bus_a, 16'h8001);
        // Reset over a pending write and flag load
        rf.write_enable = 1'b1; rf.dest_addr = 3'd2; rf.md_select = 1'b0;
        rf.function_result = 16'hFFFF; rf.flag_load = 1'b1;
        {rf.overflow, rf.carry_out, rf.negative, rf.zero} = 4'b1111;
        #1 rst_n = 1'b0;
        step();
        idle();
        rst_n = 1'b1;
        rf.addr_a = 3'd2; rf.addr_b = 3'd3; rf.mb_select = 1'b0;
        #1 chk("reset R2", rf.bus_a, 16'h0000);
        chk("reset R3", rf.data_out, 16'h0000);
        chk("reset status mid", st(), 16'h0000);
        // First edge after release behaves normally
        rf.write_enable = 1'b1; rf.dest_addr = 3'd1; rf.function_result = 16'h0F0F;
        step();
        idle();
        rf.addr_a = 3'd1;
        #1 chk("post reset write", rf.bus_a, 16'h0F0F);
        // Zero register behaviour
        rf.write_enable = 1'b1; rf.dest_addr = 3'd0; rf.md_select = 1'b0;
        rf.function_result = 16'hBEEF;
        step();
        idle();
        rf.addr_a = 3'd0; rf.addr_b = 3'd0;
        #1 chk("R0 write", rf.bus_a, ZREG ? 16'h0000 : 16'hBEEF);
        chk("R0 data_out", rf.data_out, ZREG ? 16'h0000 : 16'hBEEF);
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
